// File: rtl/conv_sched_arbiter.sv
// Round-robin scheduler sharing one 8-bit code-converter core among N requesters.
// Optional watchdog enabled by defining CONV_TIMEOUT_EN.
module conv_sched_arbiter #(
  parameter int N              = 4,
  parameter int PTR_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_mode,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [7:0]     rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic           conv_start,
  output logic [7:0]     conv_data,
  output logic           conv_mode,
  input  logic           conv_done,
  input  logic [7:0]     conv_result
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, DRAIN} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr, owner, winner;
  logic             found;
  logic [N-1:0]     owner_oh;
  logic [7:0]       sel_data;
  logic             sel_mode;
  logic             timeout;
  int               cand;

  // Search starts just past the last owner, so the previous winner is lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == cand) && req[i]) begin
          found  = 1'b1;
          winner = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    owner_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == PTR_W'(i)) begin
        sel_data = req_data[i*8 +: 8];
        sel_mode = req_mode[i];
      end
      owner_oh[i] = (owner == PTR_W'(i));
    end
  end

`ifdef CONV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        tmo_cnt <= '0;
        err_q   <= 1'b0;
      end else if (state == WAIT || state == DRAIN) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == WAIT && !conv_done && timeout)
        err_q <= 1'b1;
    end
  end

  // The cycle whose increment would reach the limit is the last one allowed.
  assign timeout = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = (state == RESP) && err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    gnt        = '0;
    rsp_valid  = '0;
    conv_start = 1'b0;
    case (state)
      IDLE:   if (found) state_next = LAUNCH;
      LAUNCH: begin
        gnt        = owner_oh;
        conv_start = 1'b1;
        state_next = WAIT;
      end
      WAIT:   if (conv_done || timeout) state_next = RESP;
      RESP: begin
        rsp_valid  = owner_oh;
        state_next = conv_done ? DRAIN : IDLE;
      end
      // A done still held from the finished job must not complete the next one.
      DRAIN:  if (!conv_done || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= PTR_W'(N - 1);
      owner     <= '0;
      conv_data <= '0;
      conv_mode <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          owner     <= winner;
          conv_data <= sel_data;
          conv_mode <= sel_mode;
        end
        LAUNCH: ptr <= owner;
        WAIT: begin
          if (conv_done)
            rsp_data <= conv_result;
          else if (timeout)
            rsp_data <= 8'h00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sched_arbiter.sv
// Directed bench for conv_sched_arbiter with a small clocked model of the converter core.
module tb_conv_sched_arbiter;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_mode, gnt, rsp_valid;
  logic [8*N-1:0] req_data;
  logic [7:0]     rsp_data, conv_data, conv_result;
  logic           rsp_err, busy, conv_start, conv_mode, conv_done;

  int assert_count = 0;
  int fail_count   = 0;
  int rsp_count    = 0;

  int         model_lat   = 10;
  int         model_hold  = 1;
  bit         model_never = 1'b0;
  int         lat_cnt     = 0;
  int         hold_cnt    = 0;
  bit         pending     = 1'b0;
  logic [7:0] cap_data    = '0;
  logic       cap_mode    = 1'b0;

  always #5 clk = ~clk;

  conv_sched_arbiter #(.N(N), .PTR_W(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_mode(req_mode),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .conv_start(conv_start), .conv_data(conv_data), .conv_mode(conv_mode),
    .conv_done(conv_done), .conv_result(conv_result)
  );

  function automatic logic [7:0] core_fn(input logic [7:0] d, input logic m);
    return m ? ~d : d + 8'd3;
  endfunction

  // Converter core: result after model_lat clocks, done held for model_hold clocks.
  always @(posedge clk) begin
    if (reset) begin
      conv_done   <= 1'b0;
      conv_result <= '0;
      pending     <= 1'b0;
      lat_cnt     <= 0;
      hold_cnt    <= 0;
    end else if (conv_start) begin
      pending   <= 1'b1;
      lat_cnt   <= model_lat;
      conv_done <= 1'b0;
      cap_data  <= conv_data;
      cap_mode  <= conv_mode;
    end else if (pending) begin
      if (lat_cnt <= 1) begin
        pending <= 1'b0;
        if (!model_never) begin
          conv_done   <= 1'b1;
          conv_result <= core_fn(cap_data, cap_mode);
          hold_cnt    <= model_hold;
        end
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (conv_done) begin
      if (hold_cnt <= 1) conv_done <= 1'b0;
      else hold_cnt <= hold_cnt - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      checkOutput("rsp_onehot", 32'($onehot0(rsp_valid)), 32'd1);
      if (rsp_valid != '0) rsp_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic on, input logic [7:0] data, input logic mode);
    req[idx]              = on;
    req_data[idx*8 +: 8]  = data;
    req_mode[idx]         = mode;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_gnt(input int budget, output int waited);
    waited = 0;
    while (gnt == '0 && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput("gnt_wait", 32'(gnt != '0), 32'd1);
  endtask

  task automatic wait_rsp(input int budget, output int waited);
    waited = 0;
    while (rsp_valid == '0 && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput("rsp_wait", 32'(rsp_valid != '0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int         w;
    int         c0;
    int         order[5]   = '{0, 1, 2, 3, 0};
    logic [7:0] t2_res[5]  = '{8'h13, 8'hEE, 8'h15, 8'hEC, 8'h13};
    logic [7:0] t2_dat[5]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    reset = 1'b1; req = '0; req_data = '0; req_mode = '0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_gnt", 32'(gnt), 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_start", 32'(conv_start), 0);
    checkOutput("rst_conv_data", 32'(conv_data), 0);
    checkOutput("rst_conv_mode", 32'(conv_mode), 0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 0);
    reset = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(busy), 0);

    // Single job on requester 0
    model_lat = 10; model_hold = 1;
    applyStimulus(0, 1'b1, 8'h0B, 1'b0);
    wait_gnt(20, w);
    checkOutput("t1_gnt_lat", 32'(w), 1);
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    checkOutput("t1_start", 32'(conv_start), 1);
    checkOutput("t1_conv_data", 32'(conv_data), 32'h0B);
    checkOutput("t1_conv_mode", 32'(conv_mode), 0);
    checkOutput("t1_busy", 32'(busy), 1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("t1_start_pulse", 32'(conv_start), 0);
    checkOutput("t1_data_hold", 32'(conv_data), 32'h0B);
    wait_rsp(40, w);
    checkOutput("t1_rsp_lat", 32'(w), 11);
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_rsp_data", 32'(rsp_data), 32'h0E);
    checkOutput("t1_rsp_err", 32'(rsp_err), 0);
    tick();
    checkOutput("t1_rsp_pulse", 32'(rsp_valid), 0);
    checkOutput("t1_rsp_hold", 32'(rsp_data), 32'h0E);
    checkOutput("t1_idle", 32'(busy), 0);

    // All four requesters continuously
    do_reset();
    model_lat = 2; model_hold = 1;
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 8'h10 + 8'(i), 1'(i % 2));
    for (int j = 0; j < 5; j++) begin
      wait_gnt(20, w);
      checkOutput("t2_gnt", 32'(gnt), 32'(1) << order[j]);
      checkOutput("t2_conv_data", 32'(conv_data), 32'(t2_dat[j]));
      checkOutput("t2_conv_mode", 32'(conv_mode), 32'(order[j] % 2));
      wait_rsp(20, w);
      checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'(1) << order[j]);
      checkOutput("t2_rsp_data", 32'(rsp_data), 32'(t2_res[j]));
    end
    req = '0;
    tick();
    tick();
    tick();
    checkOutput("t2_idle", 32'(busy), 0);

    // Level-held done keeps the arbiter draining
    do_reset();
    model_lat = 2; model_hold = 5;
    applyStimulus(0, 1'b1, 8'h05, 1'b0);
    wait_gnt(20, w);
    checkOutput("t3_gnt0", 32'(gnt), 32'h1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    applyStimulus(2, 1'b1, 8'h22, 1'b0);
    c0 = rsp_count;
    wait_rsp(20, w);
    checkOutput("t3_rsp0", 32'(rsp_valid), 32'h1);
    checkOutput("t3_rsp0_data", 32'(rsp_data), 32'h08);
    model_hold = 1;
    wait_gnt(30, w);
    checkOutput("t3_drain_gap", 32'(w), 6);
    checkOutput("t3_gnt2", 32'(gnt), 32'h4);
    checkOutput("t3_conv_data", 32'(conv_data), 32'h22);
    checkOutput("t3_one_rsp", 32'(rsp_count - c0), 1);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    wait_rsp(20, w);
    checkOutput("t3_rsp2", 32'(rsp_valid), 32'h4);
    checkOutput("t3_rsp2_data", 32'(rsp_data), 32'h25);
    tick();
    tick();
    checkOutput("t3_idle", 32'(busy), 0);

    // Reset in the middle of WAIT
    do_reset();
    model_lat = 20; model_hold = 1;
    applyStimulus(2, 1'b1, 8'h44, 1'b1);
    wait_gnt(20, w);
    checkOutput("t4_gnt2", 32'(gnt), 32'h4);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    c0 = rsp_count;
    reset = 1'b1;
    tick();
    checkOutput("t4_busy", 32'(busy), 0);
    checkOutput("t4_gnt", 32'(gnt), 0);
    checkOutput("t4_start", 32'(conv_start), 0);
    checkOutput("t4_conv_data", 32'(conv_data), 0);
    checkOutput("t4_conv_mode", 32'(conv_mode), 0);
    checkOutput("t4_rsp_data", 32'(rsp_data), 0);
    reset = 1'b0;
    repeat (30) tick();
    checkOutput("t4_no_rsp", 32'(rsp_count - c0), 0);
    checkOutput("t4_idle", 32'(busy), 0);
    model_lat = 2;
    applyStimulus(0, 1'b1, 8'h01, 1'b0);
    applyStimulus(3, 1'b1, 8'h03, 1'b1);
    wait_gnt(20, w);
    checkOutput("t4_first_gnt", 32'(gnt), 32'h1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    wait_rsp(20, w);
    checkOutput("t4_rsp0", 32'(rsp_valid), 32'h1);
    checkOutput("t4_rsp0_data", 32'(rsp_data), 32'h04);
    wait_gnt(20, w);
    checkOutput("t4_second_gnt", 32'(gnt), 32'h8);
    applyStimulus(3, 1'b0, 8'h00, 1'b0);
    wait_rsp(20, w);
    checkOutput("t4_rsp3", 32'(rsp_valid), 32'h8);
    checkOutput("t4_rsp3_data", 32'(rsp_data), 32'hFC);

    // Pointer at 1, requesters 1 and 3 collide
    do_reset();
    model_lat = 2; model_hold = 1;
    applyStimulus(1, 1'b1, 8'h11, 1'b0);
    wait_gnt(20, w);
    checkOutput("t5_gnt1", 32'(gnt), 32'h2);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    wait_rsp(20, w);
    tick();
    applyStimulus(1, 1'b1, 8'h31, 1'b0);
    applyStimulus(3, 1'b1, 8'h33, 1'b1);
    wait_gnt(20, w);
    checkOutput("t5_gnt3", 32'(gnt), 32'h8);
    checkOutput("t5_mode3", 32'(conv_mode), 1);
    checkOutput("t5_data3", 32'(conv_data), 32'h33);
    applyStimulus(3, 1'b0, 8'h00, 1'b0);
    wait_rsp(20, w);
    checkOutput("t5_rsp3", 32'(rsp_valid), 32'h8);
    checkOutput("t5_rsp3_data", 32'(rsp_data), 32'hCC);
    wait_gnt(20, w);
    checkOutput("t5_gnt1b", 32'(gnt), 32'h2);
    checkOutput("t5_mode1", 32'(conv_mode), 0);
    checkOutput("t5_data1", 32'(conv_data), 32'h31);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    wait_rsp(20, w);
    checkOutput("t5_rsp1", 32'(rsp_valid), 32'h2);
    checkOutput("t5_rsp1_data", 32'(rsp_data), 32'h34);

`ifdef CONV_TIMEOUT_EN
    // Core never finishes; watchdog aborts the job
    do_reset();
    model_never = 1'b1;
    applyStimulus(2, 1'b1, 8'h55, 1'b0);
    wait_gnt(20, w);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    wait_rsp(TMO + 20, w);
    checkOutput("t6_tmo_lat", 32'(w), 32'(TMO + 1));
    checkOutput("t6_rsp_valid", 32'(rsp_valid), 32'h4);
    checkOutput("t6_rsp_err", 32'(rsp_err), 1);
    checkOutput("t6_rsp_data", 32'(rsp_data), 0);
    model_never = 1'b0;
    applyStimulus(0, 1'b1, 8'h20, 1'b0);
    wait_gnt(20, w);
    checkOutput("t6_next_gnt", 32'(gnt), 32'h1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    wait_rsp(20, w);
    checkOutput("t6_next_rsp", 32'(rsp_valid), 32'h1);
    checkOutput("t6_next_err", 32'(rsp_err), 0);
    checkOutput("t6_next_data", 32'(rsp_data), 32'h23);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/conv_sched_arbiter.md
Name: conv_sched_arbiter

Overview:
- Round-robin scheduler that shares one 8-bit code-converter core (control unit plus datapath) among N requesters.
- Accepts one job at a time: captures the winner's operand and mode, launches the core, waits for its done, then returns the result to the owning requester.
- Sits between client blocks and the converter top; it is the only driver of the core's data_in, convert and start inputs.

Parameters:
- N, 4, number of requesters (2..8)
- PTR_W, 2, width of grant pointer, equal to clog2(N)
- TIMEOUT_CYCLES, 64, watchdog limit in clocks; used only with CONV_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  N  per-requester job request, level
- req_data  in  8*N  operand; slice i belongs to requester i
- req_mode  in  N  convert select per requester, passed to the core's convert input
- gnt  out  N  one-hot, 1-cycle pulse: job accepted
- rsp_valid  out  N  one-hot, 1-cycle pulse: result ready for requester i
- rsp_data  out  8  result, valid while any rsp_valid bit is high
- rsp_err  out  1  job aborted by watchdog; pulses with rsp_valid
- busy  out  1  high in every state except IDLE
- conv_start  out  1  to core start
- conv_data  out  8  to core data_in
- conv_mode  out  1  to core convert
- conv_done  in  1  from core done
- conv_result  in  8  from core data_out

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. While reset is high at a rising edge:
  - state goes to IDLE; gnt, rsp_valid, rsp_err, conv_start and busy are 0; conv_data, conv_mode and rsp_data are 0.
  - the round-robin pointer goes to N-1, so requester 0 has first priority.
  - reset mid-job abandons the job silently; no rsp_valid is issued.
- State machine:
  - IDLE: if any req bit is high, choose the winner by searching from pointer+1 upward, wrapping modulo N. Latch the winner's req_data and req_mode into conv_data/conv_mode, latch its index as owner, go to LAUNCH. If no request, stay.
  - LAUNCH (1 cycle): gnt[owner]=1, conv_start=1, pointer<=owner. Go to WAIT.
  - WAIT: conv_start=0. When conv_done=1, latch conv_result into rsp_data and go to RESP.
  - RESP (1 cycle): rsp_valid[owner]=1. If conv_done=0, go to IDLE; otherwise go to DRAIN.
  - DRAIN: wait for conv_done=0, then go to IDLE. Prevents a level-held done from completing the next job.
- Timing and latency:
  - gnt asserts 1 cycle after req is sampled high in IDLE.
  - rsp_valid asserts 1 cycle after conv_done is sampled high.
  - Minimum spacing from one gnt to the next is 4 cycles.
- Data stability: conv_data and conv_mode are held constant from LAUNCH until the next IDLE capture. rsp_data holds its value until the next RESP.
- Requester rules:
  - A requester holds req and req_data stable until it sees gnt.
  - Keeping req high after gnt queues another job, which competes fairly in the next IDLE.
  - A req that drops before grant is simply not served.
- Simultaneous requests: exactly one grant per arbitration. An owner just served is lowest priority next time. No requester waits more than N-1 other jobs.
- Edge cases:
  - conv_done already high when entering WAIT completes immediately; the core is responsible for clearing done on start.
  - All rsp_valid and gnt outputs are one-hot or zero at all times.

Optional Feature:
- Macro: CONV_TIMEOUT_EN
- Defined:
  - A cycle counter (width clog2(TIMEOUT_CYCLES+1)) clears in LAUNCH and increments in WAIT and DRAIN.
  - Reaching TIMEOUT_CYCLES in WAIT forces RESP with rsp_data=8'h00 and rsp_err=1.
  - Reaching TIMEOUT_CYCLES in DRAIN forces IDLE.
- Undefined: no counter. WAIT and DRAIN wait indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset then single job: req[0] with data 8'h0B, mode 0; core model returns 8'h0E after 10 cycles -> gnt[0] at cycle +1, conv_start 1-cycle pulse with conv_data=8'h0B, rsp_valid[0] with rsp_data=8'h0E exactly 1 cycle after done.
- All four requesters asserted continuously after reset -> grant order 0,1,2,3,0 with no repeats; each rsp_valid bit matches the preceding gnt bit.
- Core holds done high for 5 cycles after the job while req[2] is pending -> arbiter stays in DRAIN; gnt[2] appears only after done falls; one rsp_valid per job.
- reset asserted 3 cycles into WAIT -> next cycle busy=0 and all outputs 0; no rsp_valid ever issued for the aborted job; the next request from req[0] wins first.
- req[1] and req[3] rise in the same cycle with pointer=1 -> gnt[3] first, then gnt[1]; conv_mode follows each requester's req_mode bit.
- CONV_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, core never asserts done -> rsp_valid[owner] with rsp_err=1 and rsp_data=8'h00 at cycle 64 of WAIT; the arbiter then serves the next request.
